// File: rtl/aes_job_scheduler_pkg.sv
`default_nettype none
// aes_job_scheduler_pkg: job and scheduler-state types shared by the scheduler, its tag FIFO and the bench.
package aes_job_scheduler_pkg;

  typedef enum logic [1:0] {
    INVALID = 2'd0,
    ENCRYPT = 2'd1,
    DECRYPT = 2'd2
  } job_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } sched_state_t;

  localparam int BLOCK_W = 128;

endpackage
`default_nettype wire

// File: rtl/aes_job_scheduler_tag_fifo.sv
`default_nettype none
// aes_tag_fifo: requester-ID FIFO, one entry per job in the engine pipeline.
// Push is accepted when full as long as a pop happens in the same cycle.
module aes_tag_fifo #(
  parameter int DEPTH = 10,
  parameter int WIDTH = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_push_tag,
  input  logic                           i_pop,
  output logic [WIDTH-1:0]               o_head,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_tag;
  end

endmodule
`default_nettype wire

// File: rtl/aes_job_scheduler.sv
`default_nettype none
// aes_job_scheduler: round-robin job issue into a shared AES engine, tag-routed results,
// halt-based backpressure and drained key changes.
module aes_job_scheduler
  import aes_job_scheduler_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ENGINE_LAT = 10
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  job_t [NUM_REQ-1:0]                  req_type,
  input  logic [NUM_REQ-1:0][BLOCK_W-1:0]     req_data,
  input  logic                                key_valid,
  output logic                                key_ready,
  input  logic [BLOCK_W-1:0]                  key_in,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  input  logic [NUM_REQ-1:0]                  rsp_ready,
  output logic [BLOCK_W-1:0]                  rsp_data,
  output job_t                                rsp_type,
  output job_t                                eng_in_type,
  output logic                                eng_set_key,
  output logic                                eng_halt,
  output logic [BLOCK_W-1:0]                  eng_state,
  output logic [BLOCK_W-1:0]                  eng_key,
  input  logic [BLOCK_W-1:0]                  eng_out,
  input  job_t                                eng_out_type,
  output logic [$clog2(ENGINE_LAT+1)-1:0]     inflight,
  output logic                                key_loaded
);

  localparam int TAG_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(ENGINE_LAT+1);

  sched_state_t       r_state;
  sched_state_t       w_state_next;
  logic               r_key_loaded;
  logic [TAG_W-1:0]   r_rr_ptr;
  logic [BLOCK_W-1:0] r_eng_state;

  logic               w_found;
  logic [TAG_W-1:0]   w_gnt_idx;
  logic               w_can_issue;
  logic               w_grant;
  logic               w_issue;
  logic               w_out_valid;
  logic               w_head_ready;
  logic               w_pop;
  logic [TAG_W-1:0]   w_head;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [CNT_W-1:0]   w_count;

  // Round-robin search starting at the pointer.
  always_comb begin : arb
    logic [TAG_W-1:0] idx;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = TAG_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[idx]) begin
        w_found   = 1'b1;
        w_gnt_idx = idx;
      end
    end
  end

  assign w_out_valid  = (eng_out_type != INVALID);
  assign w_head_ready = rsp_ready[w_head];
  assign w_pop        = w_out_valid & w_head_ready;
  assign eng_halt     = w_out_valid & ~w_head_ready;

  // A pending key change takes priority over any request in the same cycle.
  assign w_can_issue = (r_state == RUN) & ~key_valid & r_key_loaded & ~eng_halt
                     & (~w_fifo_full | w_pop);
  assign w_grant     = w_can_issue & w_found;
  assign w_issue     = w_grant & (req_type[w_gnt_idx] != INVALID);

  assign req_ready   = w_grant ? (NUM_REQ'(1) << w_gnt_idx) : '0;
  assign eng_in_type = w_issue ? req_type[w_gnt_idx] : INVALID;
  assign eng_state   = w_issue ? req_data[w_gnt_idx] : r_eng_state;
  assign eng_key     = key_in;

  assign rsp_valid   = w_out_valid ? (NUM_REQ'(1) << w_head) : '0;
  assign rsp_data    = w_out_valid ? eng_out : '0;
  assign rsp_type    = eng_out_type;
  assign inflight    = w_count;
  assign key_loaded  = r_key_loaded;

  always_comb begin
    w_state_next = r_state;
    key_ready    = 1'b0;
    eng_set_key  = 1'b0;
    case (r_state)
      RUN:     if (key_valid) w_state_next = DRAIN;
      DRAIN:   if (w_count == '0) w_state_next = LOAD;
      LOAD: begin
        key_ready    = 1'b1;
        eng_set_key  = 1'b1;
        w_state_next = RUN;
      end
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_key_loaded <= 1'b0;
      r_rr_ptr     <= '0;
      r_eng_state  <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == LOAD) r_key_loaded <= 1'b1;
      if (w_grant) begin
        r_rr_ptr <= (w_gnt_idx == TAG_W'(NUM_REQ-1)) ? '0 : w_gnt_idx + TAG_W'(1);
      end
      if (w_issue) r_eng_state <= req_data[w_gnt_idx];
    end
  end

  aes_tag_fifo #(
    .DEPTH (ENGINE_LAT),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_issue),
    .i_push_tag (w_gnt_idx),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty),
    .o_count    (w_count)
  );

  a_result_has_tag: assert property (@(posedge clk) disable iff (!rst_n)
                                     !(w_out_valid && w_fifo_empty))
    else $fatal(1, "aes_job_scheduler: engine result with no tag in flight");

endmodule
`default_nettype wire

// File: tb/tb_aes_job_scheduler.sv
`default_nettype none
// tb_aes_job_scheduler: directed scenarios against the scheduler, with a cycle-accurate
// stand-in for aes_engine (pipeline of ENGINE_LAT stages, frozen by halt).
module tb_aes_job_scheduler;
  import aes_job_scheduler_pkg::*;

  localparam int NREQ = 2;
  localparam int LAT  = 10;
  localparam logic [127:0] K0    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K1    = 128'h0;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_K1 = 128'h55447766110033_22ddccffee9988bbaa;

  logic                         clk;
  logic                         rst_n;
  logic [NREQ-1:0]              req_valid;
  logic [NREQ-1:0]              req_ready;
  job_t [NREQ-1:0]              req_type;
  logic [NREQ-1:0][127:0]       req_data;
  logic                         key_valid;
  logic                         key_ready;
  logic [127:0]                 key_in;
  logic [NREQ-1:0]              rsp_valid;
  logic [NREQ-1:0]              rsp_ready;
  logic [127:0]                 rsp_data;
  job_t                         rsp_type;
  job_t                         eng_in_type;
  logic                         eng_set_key;
  logic                         eng_halt;
  logic [127:0]                 eng_state;
  logic [127:0]                 eng_key;
  logic [127:0]                 eng_out;
  job_t                         eng_out_type;
  logic [$clog2(LAT+1)-1:0]     inflight;
  logic                         key_loaded;

  int checks = 0;
  int errors = 0;

  aes_job_scheduler #(.NUM_REQ(NREQ), .ENGINE_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type), .req_data(req_data),
    .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_type(rsp_type),
    .eng_in_type(eng_in_type), .eng_set_key(eng_set_key), .eng_halt(eng_halt),
    .eng_state(eng_state), .eng_key(eng_key), .eng_out(eng_out), .eng_out_type(eng_out_type),
    .inflight(inflight), .key_loaded(key_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine stand-in: knows the FIPS-197 C.1 vector, otherwise a keyed XOR per job type.
  function automatic logic [127:0] eng_fn(input job_t t, input logic [127:0] s, input logic [127:0] k);
    logic [1:0] tv;
    tv = t;
    if (k == K0 && t == ENCRYPT && s == PT) return CT;
    if (k == K0 && t == DECRYPT && s == CT) return PT;
    return s ^ k ^ {64{tv}};
  endfunction

  job_t         st_type [LAT];
  logic [127:0] st_data [LAT];
  logic [127:0] st_key  [LAT];
  logic [127:0] m_key;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        st_type[i] <= INVALID;
        st_data[i] <= '0;
        st_key[i]  <= '0;
      end
      m_key <= '0;
    end else begin
      if (eng_set_key) m_key <= eng_key;
      if (!eng_halt) begin
        st_type[0] <= eng_in_type;
        st_data[0] <= eng_state;
        st_key[0]  <= m_key;
        for (int i = 1; i < LAT; i++) begin
          st_type[i] <= st_type[i-1];
          st_data[i] <= st_data[i-1];
          st_key[i]  <= st_key[i-1];
        end
      end
    end
  end

  assign eng_out_type = st_type[LAT-1];
  assign eng_out      = (st_type[LAT-1] == INVALID) ? '0
                      : eng_fn(st_type[LAT-1], st_data[LAT-1], st_key[LAT-1]);

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; key_valid = 1'b0; key_in = '0; rsp_ready = 2'b11;
    req_type[0] = INVALID; req_type[1] = INVALID; req_data[0] = '0; req_data[1] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready got %b exp 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid got %b exp 00", rsp_valid); end
    checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL rst_key_ready got %b exp 0", key_ready); end
    checks++; if (eng_set_key !== 1'b0) begin errors++; $display("FAIL rst_set_key got %b exp 0", eng_set_key); end
    checks++; if (eng_halt !== 1'b0) begin errors++; $display("FAIL rst_halt got %b exp 0", eng_halt); end
    checks++; if (eng_in_type !== INVALID) begin errors++; $display("FAIL rst_in_type got %0d exp 0", eng_in_type); end
    checks++; if (eng_state !== 128'h0) begin errors++; $display("FAIL rst_eng_state got %h exp 0", eng_state); end
    checks++; if (rsp_data !== 128'h0) begin errors++; $display("FAIL rst_rsp_data got %h exp 0", rsp_data); end
    checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL rst_inflight got %0d exp 0", inflight); end
    checks++; if (key_loaded !== 1'b0) begin errors++; $display("FAIL rst_key_loaded got %b exp 0", key_loaded); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_key_first();
    logic e;
    req_type[0] = ENCRYPT; req_data[0] = PT; req_valid = 2'b01;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL nokey_req_ready c=%0d got %b exp 00", c, req_ready); end
      @(posedge clk); #1;
    end
    key_in = K0; key_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      e = (c == 2);
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL keyload_req_ready c=%0d got %b exp 00", c, req_ready); end
      checks++; if (key_ready !== e) begin errors++; $display("FAIL keyload_key_ready c=%0d got %b exp %b", c, key_ready, e); end
      checks++; if (eng_set_key !== e) begin errors++; $display("FAIL keyload_set_key c=%0d got %b exp %b", c, eng_set_key, e); end
      checks++; if (eng_key !== K0) begin errors++; $display("FAIL keyload_eng_key got %h exp %h", eng_key, K0); end
      @(posedge clk); #1;
    end
    key_valid = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL enc_grant got %b exp 01", req_ready); end
    checks++; if (eng_in_type !== ENCRYPT) begin errors++; $display("FAIL enc_in_type got %0d exp 1", eng_in_type); end
    checks++; if (eng_state !== PT) begin errors++; $display("FAIL enc_eng_state got %h exp %h", eng_state, PT); end
    checks++; if (key_loaded !== 1'b1) begin errors++; $display("FAIL enc_key_loaded got %b exp 1", key_loaded); end
    checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL enc_inflight0 got %0d exp 0", inflight); end
    @(posedge clk); #1;
    req_valid = '0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++; if (inflight !== 4'd1) begin errors++; $display("FAIL enc_inflight1 got %0d exp 1", inflight); end
      end
      if (k < LAT) begin
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL enc_early_rsp k=%0d got %b exp 00", k, rsp_valid); end
      end else begin
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL enc_rsp_valid got %b exp 01", rsp_valid); end
        checks++; if (rsp_data !== CT) begin errors++; $display("FAIL enc_rsp_data got %h exp %h", rsp_data, CT); end
        checks++; if (rsp_type !== ENCRYPT) begin errors++; $display("FAIL enc_rsp_type got %0d exp 1", rsp_type); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_decrypt();
    req_type[1] = DECRYPT; req_data[1] = CT; req_valid = 2'b10;
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL dec_grant got %b exp 10", req_ready); end
    checks++; if (eng_in_type !== DECRYPT) begin errors++; $display("FAIL dec_in_type got %0d exp 2", eng_in_type); end
    @(posedge clk); #1;
    req_valid = '0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k == LAT - 1) begin
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL dec_early_rsp got %b exp 00", rsp_valid); end
      end
      if (k == LAT) begin
        checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL dec_rsp_valid got %b exp 10", rsp_valid); end
        checks++; if (rsp_data !== PT) begin errors++; $display("FAIL dec_rsp_data got %h exp %h", rsp_data, PT); end
        checks++; if (rsp_type !== DECRYPT) begin errors++; $display("FAIL dec_rsp_type got %0d exp 2", rsp_type); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]   eg;
    logic [127:0] ed;
    req_type[0] = ENCRYPT; req_data[0] = PT;
    req_type[1] = DECRYPT; req_data[1] = CT;
    req_valid = 2'b11;
    for (int i = 0; i <= 30; i++) begin
      @(negedge clk);
      if (i < 20) begin
        eg = (i % 2 == 0) ? 2'b01 : 2'b10;
        checks++; if (req_ready !== eg) begin errors++; $display("FAIL b2b_grant i=%0d got %b exp %b", i, req_ready, eg); end
      end
      if (i >= 10 && i < 30) begin
        eg = ((i - 10) % 2 == 0) ? 2'b01 : 2'b10;
        ed = ((i - 10) % 2 == 0) ? CT : PT;
        checks++; if (rsp_valid !== eg) begin errors++; $display("FAIL b2b_rsp_valid i=%0d got %b exp %b", i, rsp_valid, eg); end
        checks++; if (rsp_data !== ed) begin errors++; $display("FAIL b2b_rsp_data i=%0d got %h exp %h", i, rsp_data, ed); end
      end
      if (i == 10) begin
        checks++; if (inflight !== 4'd10) begin errors++; $display("FAIL b2b_inflight_full got %0d exp 10", inflight); end
      end
      if (i == 30) begin
        checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL b2b_inflight_end got %0d exp 0", inflight); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL b2b_rsp_end got %b exp 00", rsp_valid); end
      end
      @(posedge clk); #1;
      if (i == 19) req_valid = '0;
    end
  endtask

  task automatic test_halt();
    req_type[0] = ENCRYPT; req_data[0] = PT; req_valid = 2'b01; rsp_ready = 2'b10;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL halt_issue got %b exp 01", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 9) begin
        checks++; if (eng_halt !== 1'b0) begin errors++; $display("FAIL halt_early got %b exp 0", eng_halt); end
      end
      if (k >= 10 && k <= 14) begin
        checks++; if (eng_halt !== 1'b1) begin errors++; $display("FAIL halt_active k=%0d got %b exp 1", k, eng_halt); end
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL halt_rsp_valid k=%0d got %b exp 01", k, rsp_valid); end
        checks++; if (rsp_data !== CT) begin errors++; $display("FAIL halt_rsp_data k=%0d got %h exp %h", k, rsp_data, CT); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL halt_no_issue k=%0d got %b exp 00", k, req_ready); end
      end
      if (k == 15) begin
        checks++; if (eng_halt !== 1'b0) begin errors++; $display("FAIL halt_release got %b exp 0", eng_halt); end
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL halt_deliver got %b exp 01", rsp_valid); end
        checks++; if (rsp_data !== CT) begin errors++; $display("FAIL halt_deliver_data got %h exp %h", rsp_data, CT); end
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL halt_resume_grant got %b exp 10", req_ready); end
      end
      if (k == 25) begin
        checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL halt_r1_valid got %b exp 10", rsp_valid); end
        checks++; if (rsp_data !== PT) begin errors++; $display("FAIL halt_r1_data got %h exp %h", rsp_data, PT); end
        checks++; if (rsp_type !== DECRYPT) begin errors++; $display("FAIL halt_r1_type got %0d exp 2", rsp_type); end
      end
      @(posedge clk); #1;
      if (k + 1 == 10) req_valid = 2'b10;
      if (k + 1 == 15) rsp_ready = 2'b11;
      if (k + 1 == 16) req_valid = '0;
    end
  endtask

  task automatic test_key_change();
    logic e;
    req_type[0] = ENCRYPT; req_data[0] = PT; req_valid = 2'b01;
    for (int c = 0; c <= 28; c++) begin
      @(negedge clk);
      if (c < 6) begin
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL kc_old_grant c=%0d got %b exp 01", c, req_ready); end
      end
      if (c >= 6 && c <= 17) begin
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL kc_blocked c=%0d got %b exp 00", c, req_ready); end
        e = (c == 17);
        checks++; if (eng_set_key !== e) begin errors++; $display("FAIL kc_set_key c=%0d got %b exp %b", c, eng_set_key, e); end
      end
      if (c >= 10 && c <= 15) begin
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL kc_old_rsp c=%0d got %b exp 01", c, rsp_valid); end
        checks++; if (rsp_data !== CT) begin errors++; $display("FAIL kc_old_data c=%0d got %h exp %h", c, rsp_data, CT); end
      end
      if (c == 15) begin
        checks++; if (inflight !== 4'd1) begin errors++; $display("FAIL kc_inflight1 got %0d exp 1", inflight); end
      end
      if (c == 16) begin
        checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL kc_inflight0 got %0d exp 0", inflight); end
      end
      if (c == 17) begin
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL kc_key_ready got %b exp 1", key_ready); end
      end
      if (c == 18) begin
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL kc_new_grant got %b exp 01", req_ready); end
        checks++; if (eng_key !== K1) begin errors++; $display("FAIL kc_eng_key got %h exp %h", eng_key, K1); end
      end
      if (c == 28) begin
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL kc_new_rsp got %b exp 01", rsp_valid); end
        checks++; if (rsp_data !== PT_K1) begin errors++; $display("FAIL kc_new_data got %h exp %h", rsp_data, PT_K1); end
      end
      @(posedge clk); #1;
      if (c + 1 == 6) begin key_in = K1; key_valid = 1'b1; end
      if (c + 1 == 18) key_valid = 1'b0;
      if (c + 1 == 19) req_valid = '0;
    end
  endtask

  task automatic test_reset_midstream();
    req_type[0] = ENCRYPT; req_data[0] = PT;
    req_type[1] = DECRYPT; req_data[1] = CT;
    req_valid = 2'b11;
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL mid_grant0 got %b exp 10", req_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_grant1 got %b exp 01", req_ready); end
    checks++; if (inflight !== 4'd1) begin errors++; $display("FAIL mid_inflight got %0d exp 1", inflight); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL mid_rst_req_ready got %b exp 00", req_ready); end
    checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL mid_rst_inflight got %0d exp 0", inflight); end
    checks++; if (key_loaded !== 1'b0) begin errors++; $display("FAIL mid_rst_key_loaded got %b exp 0", key_loaded); end
    checks++; if (eng_in_type !== INVALID) begin errors++; $display("FAIL mid_rst_in_type got %0d exp 0", eng_in_type); end
    checks++; if (eng_state !== 128'h0) begin errors++; $display("FAIL mid_rst_eng_state got %h exp 0", eng_state); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL mid_rst_rsp_valid got %b exp 00", rsp_valid); end
    checks++; if (eng_halt !== 1'b0) begin errors++; $display("FAIL mid_rst_halt got %b exp 0", eng_halt); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL mid_nokey c=%0d got %b exp 00", c, req_ready); end
      @(posedge clk); #1;
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_key_first();
    test_decrypt();
    test_back_to_back();
    test_halt();
    test_key_change();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "bench did not complete");
  end

endmodule
`default_nettype wire
